button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250_000: consecutive stable synchronized samples required to accept a level change.
REQ-002 SHALL have parameter LONG_CYCLES, default 12_500_000: cycles held after accepted press before the long-press pulse.
REQ-003 clk_i  input  1  sole clock; all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 btn_ni  input  1  raw push button, active-low, asynchronous to clk_i, bouncy.
REQ-006 level_o  output  1  debounced pressed level (1 = pressed).
REQ-007 press_o  output  1  single-cycle pulse on accepted press.
REQ-008 release_o  output  1  single-cycle pulse on accepted release.
REQ-009 long_o  output  1  single-cycle pulse, at most once per press, after LONG_CYCLES held.

Function
REQ-010 SHALL pass btn_ni through a 2-flop synchronizer, then invert to btn_s (1 = pressed); raw-to-btn_s latency exactly 2 edges.
REQ-011 SHALL implement FSM states RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
REQ-012 RELEASED: btn_s=1 -> PRESS_CHK with deb_cnt<=1; else stay, deb_cnt<=0.
REQ-013 PRESS_CHK: btn_s=0 -> RELEASED, deb_cnt<=0, no pulse; btn_s=1 and deb_cnt==DEBOUNCE_CYCLES-1 -> PRESSED, level_o<=1, press_o<=1, long_cnt<=0; else deb_cnt++.
REQ-014 Accepted press therefore needs DEBOUNCE_CYCLES consecutive btn_s=1 samples; a settled raw falling edge yields press_o high after edge DEBOUNCE_CYCLES+2.
REQ-015 PRESSED: btn_s=0 -> RELEASE_CHK with deb_cnt<=1; else stay.
REQ-016 RELEASE_CHK: btn_s=1 -> PRESSED, deb_cnt<=0, no pulse, level_o stays 1; btn_s=0 and deb_cnt==DEBOUNCE_CYCLES-1 -> RELEASED, level_o<=0, release_o<=1; else deb_cnt++.
REQ-017 long_cnt SHALL increment every edge in PRESSED and RELEASE_CHK; when long_cnt==LONG_CYCLES-1 and long not yet fired, long_o<=1 for one cycle, long_done<=1, long_cnt saturates.
REQ-018 long_o edge SHALL be exactly LONG_CYCLES edges after the press_o edge for an uninterrupted hold; bounces inside RELEASE_CHK SHALL NOT reset long_cnt.
REQ-019 Entering RELEASED SHALL clear long_cnt and long_done; a release before LONG_CYCLES SHALL produce no long_o.
REQ-020 If long_o and release_o fall due on the same edge, both SHALL pulse.
REQ-021 press_o, release_o, long_o SHALL be registered and deasserted on every edge they are not explicitly set.
REQ-022 deb_cnt width SHALL be $clog2(DEBOUNCE_CYCLES); long_cnt width $clog2(LONG_CYCLES); counters never wrap.
REQ-023 Parameters: DEBOUNCE_CYCLES>=2 and LONG_CYCLES>DEBOUNCE_CYCLES; violations SHALL be flagged at elaboration.

Reset
REQ-024 rst_ni low SHALL immediately force state RELEASED, deb_cnt=0, long_cnt=0, long_done=0, synchronizer flops to released (1).
REQ-025 During and after reset all outputs SHALL be 0; reset mid-PRESS_CHK or mid-hold SHALL produce no pulse.
REQ-026 After rst_ni rises with button held, a full press qualification (REQ-014) SHALL occur before press_o.

Structure
REQ-027 FSM state enum and default cycle constants SHALL live in shared package board_pkg.
REQ-028 Synchronizer SHALL be sub-module sync_2ff (1-bit, reset value parameter); everything else in button_debounce.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-029 btn_ni 1->0 settled before edge 1, held -> press_o high after edge 6 only, level_o 1 from edge 6.
REQ-030 btn_ni low for 3 cycles then high -> no press_o, level_o 0, state RELEASED.
REQ-031 press held 20 cycles -> one long_o pulse after edge 16, none later.
REQ-032 held then btn_ni 0->1 with a 2-cycle low glitch mid-release -> level_o stays 1 through glitch, single release_o 6 edges after final settled rise.
REQ-033 rst_ni pulsed low at edge 4 of a press -> outputs 0 immediately, no press_o until 4 fresh samples after release of reset.
REQ-034 press held 8 cycles then released -> press_o and release_o once each, no long_o.

Source files
------------

// File: rtl/board_pkg.sv
// Shared board-level types and default timing for the push-button front end.
package board_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } deb_state_e;

  // Defaults assume a 50 MHz clock: 5 ms debounce, 250 ms long press.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250_000;
  localparam int unsigned LONG_CYCLES_DEF     = 12_500_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      q_o    <= RST_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces an active-low push button; emits level plus press, release and long-press pulses.
module button_debounce
  import board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int LONG_W = $clog2(LONG_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_err
    $error("button_debounce: need DEBOUNCE_CYCLES>=2 and LONG_CYCLES>DEBOUNCE_CYCLES");
  end

  logic btn_sync, btn_s;

  // Flops reset to the released (high) level so no phantom press follows reset.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (btn_ni),
    .q_o    (btn_sync)
  );

  assign btn_s = ~btn_sync;

  deb_state_e        state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              long_done_q, long_done_d;
  logic              level_d, press_d, release_d, long_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RELEASED;
      deb_cnt_q   <= '0;
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
      level_o     <= 1'b0;
      press_o     <= 1'b0;
      release_o   <= 1'b0;
      long_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      long_cnt_q  <= long_cnt_d;
      long_done_q <= long_done_d;
      level_o     <= level_d;
      press_o     <= press_d;
      release_o   <= release_d;
      long_o      <= long_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    long_cnt_d  = long_cnt_q;
    long_done_d = long_done_q;
    level_d     = level_o;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    // Hold timer runs through release bounces; it saturates so it fires once.
    if (state_q == PRESSED || state_q == RELEASE_CHK) begin
      if (long_cnt_q == LONG_LAST) begin
        if (!long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
      end else begin
        long_cnt_d = long_cnt_q + 1'b1;
      end
    end

    case (state_q)
      RELEASED: begin
        if (btn_s) begin
          state_d   = PRESS_CHK;
          deb_cnt_d = DEB_W'(1);
        end else begin
          deb_cnt_d = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_d   = RELEASED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = PRESSED;
          deb_cnt_d   = '0;
          level_d     = 1'b1;
          press_d     = 1'b1;
          long_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d   = RELEASE_CHK;
          deb_cnt_d = DEB_W'(1);
        end
      end
      RELEASE_CHK: begin
        if (btn_s) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          // A long pulse due on this same edge is still emitted above.
          state_d     = RELEASED;
          deb_cnt_d   = '0;
          level_d     = 1'b0;
          release_d   = 1'b1;
          long_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

endmodule

// File: tb/tb_button_debounce.sv
// Randomized and directed bench for button_debounce against a sample-window reference model.
module tb_button_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 10;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  logic btn_ni = 1'b1;
  logic level_o, press_o, release_o, long_o;

  button_debounce #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .btn_ni    (btn_ni),
    .level_o   (level_o),
    .press_o   (press_o),
    .release_o (release_o),
    .long_o    (long_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: btn_s is the raw level two edges ago, inverted; the level
  // flips once the last DEB samples all disagree with it; long fires LONG edges
  // after a press if the level was still high going into that edge.
  bit   r_m1 = 1'b1, r_m2 = 1'b1;
  bit   samp_q[$];
  bit   m_level = 1'b0;
  int   held = 0;
  bit   fired = 1'b0;
  logic [3:0] exp_vec = 4'b0;

  // Observation bookkeeping for directed timing checks.
  int edge_no = 0;
  int n_press = 0, n_rel = 0, n_long = 0;
  int press_edge = -1, rel_edge = -1, long_edge = -1;

  bit seq[$];

  task automatic add_run(input bit v, input int n);
    for (int i = 0; i < n; i++) seq.push_back(v);
  endtask

  task automatic clear_obs();
    edge_no = 0; n_press = 0; n_rel = 0; n_long = 0;
    press_edge = -1; rel_edge = -1; long_edge = -1;
  endtask

  task automatic cycle(input bit raw);
    bit s, all_diff, e_press, e_rel, e_long;
    btn_ni = raw;
    @(posedge clk_i);
    edge_no++;
    e_press = 0; e_rel = 0; e_long = 0;
    if (!rst_ni) begin
      r_m1 = 1'b1; r_m2 = 1'b1;
      samp_q.delete();
      m_level = 1'b0; held = 0; fired = 1'b0;
    end else begin
      s = ~r_m2;
      r_m2 = r_m1;
      r_m1 = raw;
      samp_q.push_back(s);
      if (samp_q.size() > DEB) void'(samp_q.pop_front());
      if (m_level) begin
        held++;
        if (held == LONG && !fired) begin e_long = 1; fired = 1'b1; end
      end
      all_diff = (samp_q.size() == DEB);
      foreach (samp_q[i]) if (samp_q[i] == m_level) all_diff = 0;
      if (all_diff) begin
        m_level = ~m_level;
        if (m_level) begin e_press = 1; held = 0; fired = 1'b0; end
        else e_rel = 1;
      end
    end
    exp_vec = {m_level, e_press, e_rel, e_long};
    #1;
    if (press_o   === 1'b1) begin n_press++; press_edge = edge_no; end
    if (release_o === 1'b1) begin n_rel++;   rel_edge   = edge_no; end
    if (long_o    === 1'b1) begin n_long++;  long_edge  = edge_no; end
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    #1;
    total++;
    if ({level_o, press_o, release_o, long_o} !== 4'b0) begin
      bad++; $display("FAIL reset_async got=%b exp=0000", {level_o, press_o, release_o, long_o});
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      total++;
      if ({level_o, press_o, release_o, long_o} !== exp_vec) begin
        bad++; $display("FAIL reset_hold edge=%0d got=%b exp=%b", edge_no, {level_o, press_o, release_o, long_o}, exp_vec);
      end
    end
    rst_ni = 1'b1;
    seq.delete(); add_run(1, 8);
    foreach (seq[i]) begin
      cycle(seq[i]);
      total++;
      if ({level_o, press_o, release_o, long_o} !== exp_vec) begin
        bad++; $display("FAIL reset_idle edge=%0d got=%b exp=%b", edge_no, {level_o, press_o, release_o, long_o}, exp_vec);
      end
    end
  endtask

  task automatic test_press_long();
    clear_obs();
    seq.delete(); add_run(0, 20); add_run(1, 12);
    foreach (seq[i]) begin
      cycle(seq[i]);
      total++;
      if ({level_o, press_o, release_o, long_o} !== exp_vec) begin
        bad++; $display("FAIL press_long edge=%0d got=%b exp=%b", edge_no, {level_o, press_o, release_o, long_o}, exp_vec);
      end
    end
    total++;
    if (press_edge !== 6 || n_press !== 1) begin
      bad++; $display("FAIL press_latency edge=%0d count=%0d exp edge=6 count=1", press_edge, n_press);
    end
    total++;
    if (long_edge !== 16 || n_long !== 1) begin
      bad++; $display("FAIL long_latency edge=%0d count=%0d exp edge=16 count=1", long_edge, n_long);
    end
  endtask

  task automatic test_short_glitch();
    clear_obs();
    seq.delete(); add_run(0, 3); add_run(1, 10);
    foreach (seq[i]) begin
      cycle(seq[i]);
      total++;
      if ({level_o, press_o, release_o, long_o} !== exp_vec) begin
        bad++; $display("FAIL short_glitch edge=%0d got=%b exp=%b", edge_no, {level_o, press_o, release_o, long_o}, exp_vec);
      end
    end
    total++;
    if (n_press !== 0 || level_o !== 1'b0) begin
      bad++; $display("FAIL short_no_press presses=%0d level=%b exp 0/0", n_press, level_o);
    end
  endtask

  task automatic test_release_glitch();
    seq.delete(); add_run(0, 25); add_run(1, 2); add_run(0, 2);
    foreach (seq[i]) begin
      cycle(seq[i]);
      total++;
      if ({level_o, press_o, release_o, long_o} !== exp_vec) begin
        bad++; $display("FAIL rel_glitch edge=%0d got=%b exp=%b", edge_no, {level_o, press_o, release_o, long_o}, exp_vec);
      end
    end
    clear_obs();
    seq.delete(); add_run(1, 12);
    foreach (seq[i]) begin
      cycle(seq[i]);
      total++;
      if ({level_o, press_o, release_o, long_o} !== exp_vec) begin
        bad++; $display("FAIL rel_settle edge=%0d got=%b exp=%b", edge_no, {level_o, press_o, release_o, long_o}, exp_vec);
      end
    end
    total++;
    if (rel_edge !== 6 || n_rel !== 1) begin
      bad++; $display("FAIL release_latency edge=%0d count=%0d exp edge=6 count=1", rel_edge, n_rel);
    end
  endtask

  task automatic test_reset_mid_press();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0);
      total++;
      if ({level_o, press_o, release_o, long_o} !== exp_vec) begin
        bad++; $display("FAIL midrst_pre edge=%0d got=%b exp=%b", edge_no, {level_o, press_o, release_o, long_o}, exp_vec);
      end
    end
    rst_ni = 1'b0;
    #1;
    total++;
    if ({level_o, press_o, release_o, long_o} !== 4'b0) begin
      bad++; $display("FAIL midrst_async got=%b exp=0000", {level_o, press_o, release_o, long_o});
    end
    cycle(1'b0);
    cycle(1'b0);
    rst_ni = 1'b1;
    clear_obs();
    seq.delete(); add_run(0, 12); add_run(1, 10);
    foreach (seq[i]) begin
      cycle(seq[i]);
      total++;
      if ({level_o, press_o, release_o, long_o} !== exp_vec) begin
        bad++; $display("FAIL midrst_post edge=%0d got=%b exp=%b", edge_no, {level_o, press_o, release_o, long_o}, exp_vec);
      end
    end
    total++;
    if (press_edge !== 6 || n_press !== 1) begin
      bad++; $display("FAIL midrst_requal edge=%0d count=%0d exp edge=6 count=1", press_edge, n_press);
    end
  endtask

  task automatic test_short_hold();
    clear_obs();
    seq.delete(); add_run(0, 8); add_run(1, 12);
    foreach (seq[i]) begin
      cycle(seq[i]);
      total++;
      if ({level_o, press_o, release_o, long_o} !== exp_vec) begin
        bad++; $display("FAIL short_hold edge=%0d got=%b exp=%b", edge_no, {level_o, press_o, release_o, long_o}, exp_vec);
      end
    end
    total++;
    if (n_press !== 1 || n_rel !== 1 || n_long !== 0) begin
      bad++; $display("FAIL short_hold_counts p=%0d r=%0d l=%0d exp 1/1/0", n_press, n_rel, n_long);
    end
  endtask

  task automatic test_coincident();
    clear_obs();
    seq.delete(); add_run(0, 10); add_run(1, 12);
    foreach (seq[i]) begin
      cycle(seq[i]);
      total++;
      if ({level_o, press_o, release_o, long_o} !== exp_vec) begin
        bad++; $display("FAIL coincident edge=%0d got=%b exp=%b", edge_no, {level_o, press_o, release_o, long_o}, exp_vec);
      end
    end
    total++;
    if (long_edge !== 16 || rel_edge !== 16 || n_long !== 1) begin
      bad++; $display("FAIL coincident_edges long=%0d rel=%0d exp 16/16", long_edge, rel_edge);
    end
  endtask

  task automatic test_random();
    bit v = 1'b0;
    int len;
    for (int r = 0; r < 250; r++) begin
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 25) : $urandom_range(1, 6);
      if ($urandom_range(0, 40) == 0) rst_ni = 1'b0;
      for (int i = 0; i < len; i++) begin
        cycle(v);
        rst_ni = 1'b1;
        total++;
        if ({level_o, press_o, release_o, long_o} !== exp_vec) begin
          bad++; $display("FAIL random edge=%0d got=%b exp=%b", edge_no, {level_o, press_o, release_o, long_o}, exp_vec);
        end
      end
      v = ~v;
    end
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1);
      total++;
      if ({level_o, press_o, release_o, long_o} !== exp_vec) begin
        bad++; $display("FAIL random_tail edge=%0d got=%b exp=%b", edge_no, {level_o, press_o, release_o, long_o}, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_long();
    test_short_glitch();
    test_release_glitch();
    test_reset_mid_press();
    test_short_hold();
    test_coincident();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
